// File: rtl/gate_stimulus_gen_pkg.sv
// Shared types and constants for the gate stimulus sequencer.
package gate_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_VECTORS = 4;

    typedef logic [1:0] vec_t;

endpackage

// File: rtl/gate_stimulus_gen_hold_timer.sv
// Hold timer: counts 0..HOLD_CYCLES-1 while enabled, pulses tc_o on the last count.
module gate_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 40
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && !clr_i && (cnt_q == CW'(HOLD_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_stimulus_gen.sv
// Stimulus sequencer sweeping {B,A} through 00,01,10,11 for a programmable hold and pass count.
module gate_stimulus_gen
    import gate_stim_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 40,
    parameter int unsigned NUM_PASSES  = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iPause,
    output logic       oA,
    output logic       oB,
    output logic       oBusy,
    output logic       oDone,
    output logic [1:0] oVecIdx,
    output logic [7:0] oPassCnt
);

    localparam vec_t       LAST_VEC = vec_t'(NUM_VECTORS - 1);
    localparam logic [7:0] PASSES   = 8'(NUM_PASSES);

    state_t     state_q, state_d;
    vec_t       vec_q, vec_d;
    logic [7:0] pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] pass_inc;
    logic       start_take;
    logic       run_en;
    logic       tc;

    assign start_take = (state_q != RUN) && iStart;
    assign run_en     = (state_q == RUN) && !iPause;
    assign pass_inc   = pass_q + 8'd1;

    gate_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk_i (iClk),
        .rst_i (iRst),
        .clr_i (start_take),
        .en_i  (run_en),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (start_take) begin
            state_d = RUN;
            vec_d   = '0;
            pass_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (tc) begin
            if (vec_q == LAST_VEC) begin
                // Wrapping back to 00 also leaves the trailing 00 vector in DONE.
                vec_d  = '0;
                pass_d = pass_inc;
                if (pass_inc == PASSES) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                vec_d = vec_q + vec_t'(1);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oA       = vec_q[0];
    assign oB       = vec_q[1];
    assign oVecIdx  = vec_q;
    assign oPassCnt = pass_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_gate_stimulus_gen.sv
// Scoreboard bench for gate_stimulus_gen: two instances (HOLD 4 x 1 pass, HOLD 1 x 3 passes).
module tb_gate_stimulus_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st0, pa0, st1, pa1;
    logic a0, b0, busy0, done0, a1, b1, busy1, done1;
    logic [1:0] idx0, idx1;
    logic [7:0] pc0, pc1;
    logic [13:0] obs0, obs1;

    gate_stimulus_gen #(.HOLD_CYCLES(4), .NUM_PASSES(1)) dut0 (
        .iClk(clk), .iRst(rst), .iStart(st0), .iPause(pa0),
        .oA(a0), .oB(b0), .oBusy(busy0), .oDone(done0),
        .oVecIdx(idx0), .oPassCnt(pc0)
    );

    gate_stimulus_gen #(.HOLD_CYCLES(1), .NUM_PASSES(3)) dut1 (
        .iClk(clk), .iRst(rst), .iStart(st1), .iPause(pa1),
        .oA(a1), .oB(b1), .oBusy(busy1), .oDone(done1),
        .oVecIdx(idx1), .oPassCnt(pc1)
    );

    assign obs0 = {busy0, done0, b0, a0, idx0, pc0};
    assign obs1 = {busy1, done1, b1, a1, idx1, pc1};

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int scen  = 0;
    int cn    = 0;
    int busy_cnt = 0;
    int m_run = 0, m_done = 0, m_t = 0;
    logic [13:0] sb[$];

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int hold_sel();
        return (sel == 1) ? 1 : 4;
    endfunction

    function automatic int pass_sel();
        return (sel == 1) ? 3 : 1;
    endfunction

    // Expected {busy,done,B,A,idx,pass} from the active-cycle count since start.
    function automatic logic [13:0] model_obs();
        logic [1:0] idx;
        logic [7:0] pc;
        int h;
        h = hold_sel();
        if (m_run != 0) begin
            idx = 2'((m_t / h) % 4);
            pc  = 8'(m_t / (4 * h));
            return {1'b1, 1'b0, idx[1], idx[0], idx, pc};
        end else if (m_done != 0) begin
            return {1'b0, 1'b1, 2'b00, 2'b00, 8'(pass_sel())};
        end
        return '0;
    endfunction

    task automatic compare_head();
        logic [13:0] e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = (sel == 1) ? obs1 : obs0;
            check($sformatf("s%0d_c%0d", scen, cn), g, e);
            if (sel == 1 && g[13]) busy_cnt++;
        end
    endtask

    task automatic cyc(input logic s, input logic p);
        @(negedge clk);
        compare_head();
        cn++;
        st0 = (sel == 0) ? s : 1'b0;
        pa0 = (sel == 0) ? p : 1'b0;
        st1 = (sel == 1) ? s : 1'b0;
        pa1 = (sel == 1) ? p : 1'b0;
        if (m_run == 0) begin
            if (s) begin
                m_run  = 1;
                m_done = 0;
                m_t    = 0;
            end
        end else if (!p) begin
            m_t++;
            if (m_t == 4 * hold_sel() * pass_sel()) begin
                m_run  = 0;
                m_done = 1;
            end
        end
        sb.push_back(model_obs());
    endtask

    task automatic drain();
        @(negedge clk);
        compare_head();
        {st0, pa0, st1, pa1} = '0;
    endtask

    initial begin
        {st0, pa0, st1, pa1} = '0;
        rst = 1'b1;
        #1;
        check("rst0_dut0", obs0, 14'd0);
        check("rst0_dut1", obs1, 14'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sweep, HOLD=4, one pass.
        scen = 1; cn = 0;
        cyc(1'b1, 1'b0);
        repeat (19) cyc(1'b0, 1'b0);

        // Restart from DONE, with a stray start mid-run.
        scen = 2; cn = 0;
        cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (14) cyc(1'b0, 1'b0);

        // Start with pause high from DONE, then 5-cycle pause inside vector 01.
        scen = 3; cn = 0;
        cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);

        // Asynchronous reset mid-run, then a clean sweep.
        scen = 4; cn = 0;
        cyc(1'b1, 1'b0);
        repeat (9) cyc(1'b0, 1'b0);
        drain();
        #2 rst = 1'b1;
        #1 check("rst_mid", obs0, 14'd0);
        m_run = 0; m_done = 0; m_t = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        repeat (19) cyc(1'b0, 1'b0);
        drain();

        // HOLD=1, three passes.
        scen = 5; cn = 0;
        sel = 1; m_run = 0; m_done = 0; m_t = 0; busy_cnt = 0;
        cyc(1'b1, 1'b0);
        repeat (15) cyc(1'b0, 1'b0);
        drain();
        check("busy_len", 14'(busy_cnt), 14'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
